// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX-stage forwarding select and load-use stall controller
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   ex_valid     EX holds a real instruction
//   ex_regwrite  EX instruction writes ex_rd
//   ex_mem_read  EX instruction is a load
//   ex_rd        EX destination register
//   ex_src       packed EX source registers, operand i at [i*REG_AW +: REG_AW]
//   ex_src_used  per-operand "actually read" flags
//   hold         global freeze, no tag shift and no counting
//   flush_ex     kill the EX instruction as it leaves EX
//   fwd_sel      per operand: 0 = register file, k = forward from stage k
//   lu_stall     freeze IF/ID/EX and insert a bubble into stage 1
//   stall_cnt    saturating count of load-use stall cycles
module fwd_hazard_ctrl #(
  parameter int  REG_AW   = 5,
  parameter int  DEPTH    = 2,
  parameter int  NSRC     = 2,
  parameter int  LOAD_LAT = 1,
  parameter int  CNT_W    = 16,
  localparam int SELW     = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  input  logic                   ex_regwrite,
  input  logic                   ex_mem_read,
  input  logic [REG_AW-1:0]      ex_rd,
  input  logic [NSRC*REG_AW-1:0] ex_src,
  input  logic [NSRC-1:0]        ex_src_used,
  input  logic                   hold,
  input  logic                   flush_ex,
  output logic [NSRC*SELW-1:0]   fwd_sel,
  output logic                   lu_stall,
  output logic [CNT_W-1:0]       stall_cnt
);

  // Tag pipeline: array index 0 is stage 1 (EX/MEM), index DEPTH-1 is the last tracked stage.
  logic [DEPTH-1:0]             tag_v;
  logic [DEPTH-1:0]             tag_rw;
  logic [DEPTH-1:0]             tag_ld;
  logic [DEPTH-1:0][REG_AW-1:0] tag_rd;

  logic [NSRC-1:0]              lu_need;
  logic [REG_AW-1:0]            src;

  always_comb begin
    fwd_sel = '0;
    lu_need = '0;
    src     = '0;
    for (int i = 0; i < NSRC; i++) begin
      src = ex_src[i*REG_AW +: REG_AW];
      // Scan oldest to youngest so the nearest producer is the last one written.
      for (int k = DEPTH; k >= 1; k--) begin
        if (ex_src_used[i] && tag_v[k-1] && tag_rw[k-1] &&
            (tag_rd[k-1] != '0) && (tag_rd[k-1] == src)) begin
          fwd_sel[i*SELW +: SELW] = SELW'(k);
          // A nearer non-load producer overwrites this, so an older load is shadowed.
          lu_need[i] = tag_ld[k-1] && (k <= LOAD_LAT);
        end
      end
    end
  end

  assign lu_stall = ex_valid & ~flush_ex & (|lu_need);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v     <= '0;
      tag_rw    <= '0;
      tag_ld    <= '0;
      tag_rd    <= '0;
      stall_cnt <= '0;
    end else if (!hold) begin
      for (int k = 1; k < DEPTH; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_rw[k] <= tag_rw[k-1];
        tag_ld[k] <= tag_ld[k-1];
        tag_rd[k] <= tag_rd[k-1];
      end
      if (lu_stall) begin
        tag_v[0]  <= 1'b0;
        tag_rw[0] <= 1'b0;
        tag_ld[0] <= 1'b0;
        tag_rd[0] <= '0;
      end else begin
        tag_v[0]  <= ex_valid & ~flush_ex;
        tag_rw[0] <= ex_regwrite;
        tag_ld[0] <= ex_mem_read;
        tag_rd[0] <= ex_rd;
      end
      if (lu_stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule
